// File: rtl/spi_dc_slave_ctrl.sv
// Sequences host bytes into the Hamming SPI slave core, one start per byte, and captures decoded rx bytes with status.
// Optional error counters are built only when HM_ERR_CNT_EN is defined.
module spi_dc_slave_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 0,
  parameter int TO_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        core_tx_en,
  output logic        core_start,
  output logic [7:0]  core_din,
  input  logic        core_sed_qvld,
  output logic        core_rx_en,
  input  logic [7:0]  core_dout,
  input  logic        core_err_only,
  input  logic        core_err_mul,
  input  logic        core_rec_qvld,
  output logic [7:0]  rx_data,
  output logic [1:0]  rx_status,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_ovf,
  input  logic        ovf_clr,
  output logic        tx_timeout,
  output logic        busy,
  output logic [15:0] corr_cnt,
  output logic [15:0] uncorr_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [TO_W:0] GAP_LIM = (TO_W+1)'(GAP_CYCLES);
  localparam logic [TO_W:0] TO_LIM  = (TO_W+1)'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt;
  logic [TO_W:0]   cnt_inc;
  logic            pop, push, to_hit, start_c;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty;

  assign full     = (count == DEPTH_L);
  assign empty    = (count == '0);
  assign tx_ready = !rst && !full;
  assign push     = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      core_din <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        core_din <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign cnt_inc = {1'b0, cnt} + (TO_W+1)'(1);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start_c   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && !empty) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD:  state_nxt = S_START;
      S_START: begin
        start_c   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse in the same cycle as the deadline still counts as done.
        if (core_sed_qvld) begin
          state_nxt = S_GAP;
        end else if ((TIMEOUT != 0) && (cnt_inc == TO_LIM)) begin
          to_hit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_inc >= GAP_LIM) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tx_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_timeout <= to_hit;
      cnt        <= (state_nxt != state) ? '0 : cnt + TO_W'(1);
    end
  end

  assign core_start = start_c;
  assign busy       = (state != S_IDLE);
  assign core_tx_en = enable || busy;
  assign core_rx_en = enable;

  logic [1:0] rec_status;
  logic       rx_accept, rx_drop;

  assign rec_status = core_err_mul ? 2'b10 : (core_err_only ? 2'b01 : 2'b00);
  assign rx_accept  = !rx_valid || rx_ready;
  assign rx_drop    = core_rec_qvld && !rx_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      rx_status <= 2'b00;
      rx_ovf    <= 1'b0;
    end else begin
      if (core_rec_qvld && rx_accept) begin
        rx_data   <= core_dout;
        rx_status <= rec_status;
        rx_valid  <= 1'b1;
      end else if (rx_ready) begin
        rx_valid  <= 1'b0;
      end
      if (rx_drop)      rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
    end
  end

`ifdef HM_ERR_CNT_EN
  logic [15:0] corr_q, uncorr_q;

  // Dropped frames are still counted: the counters track link quality, not host delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_q   <= 16'h0000;
      uncorr_q <= 16'h0000;
    end else if (core_rec_qvld) begin
      if (rec_status == 2'b01 && corr_q != 16'hFFFF)   corr_q   <= corr_q + 16'd1;
      if (rec_status == 2'b10 && uncorr_q != 16'hFFFF) uncorr_q <= uncorr_q + 16'd1;
    end
  end

  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
`else
  assign corr_cnt   = 16'h0000;
  assign uncorr_cnt = 16'h0000;
`endif

endmodule
